// File: rtl/serial_comparator_nbit_if.sv
// serial_comparator_nbit_if: start/operand/result bundle between a requester and the comparator
interface serial_comparator_nbit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_greater_B;
  logic             A_equal_B;
  logic             A_lesser_B;
  modport master (
    output start, signed_mode, A, B,
    input  busy, done, A_greater_B, A_equal_B, A_lesser_B
  );
  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, A_greater_B, A_equal_B, A_lesser_B
  );
endinterface

// File: rtl/serial_comparator_nbit.sv
// serial_comparator_nbit: digit-serial MSB-first magnitude comparator with early termination
module serial_comparator_nbit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_comparator_nbit_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q, done_q, gt_q, eq_q, lt_q;
  logic             top;
  logic [DIGIT-1:0] msk, sa, sb;
  // signed compare of the top slice reduces to unsigned after flipping both sign bits
  always_comb begin
    top = sm_q && (idx_q == IW'(NDIG - 1));
    msk = {DIGIT{top}} & (DIGIT'(1) << (DIGIT - 1));
    sa  = DIGIT'(a_q >> (int'(idx_q) * DIGIT)) ^ msk;
    sb  = DIGIT'(b_q >> (int'(idx_q) * DIGIT)) ^ msk;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          a_q     <= bus.A;
          b_q     <= bus.B;
          sm_q    <= bus.signed_mode;
          idx_q   <= IW'(NDIG - 1);
          state_q <= RUN;
        end
      end else if (sa != sb || idx_q == '0) begin
        gt_q    <= sa > sb;
        lt_q    <= sa < sb;
        eq_q    <= sa == sb;
        done_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end
  assign bus.busy        = state_q == RUN;
  assign bus.done        = done_q;
  assign bus.A_greater_B = gt_q;
  assign bus.A_equal_B   = eq_q;
  assign bus.A_lesser_B  = lt_q;
endmodule
